spi_arbiter: RTL

- Shares the single SPI engine (start/busy/width_16/data_tx/data_rx handshake) between two requesters: the CPU-side peripheral register file and a second hardware master, such as a display-refresh or flash-fetch engine.
- Round-robin arbitration with the grant held for a whole transaction.
- Sequences the start/busy handshake and latches received data.
- Reports completion and start-timeout errors per requester.
- Sits between the peripheral block and the spi instance, entirely in the raw_clk domain.

---
 rtl/spi_arbiter_pkg.sv | 29 ++
 rtl/spi_arbiter_if.sv | 51 +++++
 rtl/spi_arbiter_rr_arb2.sv | 23 ++
 rtl/spi_arbiter.sv | 131 +++++++++++++
 4 files changed

// File: rtl/spi_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package : spi_arbiter_pkg
// Shared FSM encoding, default start timeout and round-robin pick helper.
// Rev     : 1.0
// ============================================================================
package spi_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    // Also used by the peripheral register file for its own start watchdog.
    localparam int unsigned START_TIMEOUT_DEFAULT = 255;
    localparam int unsigned TIMEOUT_W_DEFAULT     = 8;

    // Returns the index of the winning requester; a tie goes to the one not served last.
    function automatic logic rr_pick(input logic req_0, input logic req_1, input logic last_grant);
        if (req_0 && req_1) begin
            return ~last_grant;
        end
        return req_1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : spi_arbiter_if
// Requester handshakes plus the SPI engine start/busy bus around the arbiter.
// Rev       : 1.0
// ============================================================================
interface spi_arbiter_if;

    logic        req_0;
    logic        width_16_0;
    logic [15:0] tx_data_0;
    logic        grant_0;
    logic        done_0;

    logic        req_1;
    logic        width_16_1;
    logic [15:0] tx_data_1;
    logic        grant_1;
    logic        done_1;

    logic [7:0]  rx_data;
    logic        error;

    logic        spi_start;
    logic        spi_width_16;
    logic [15:0] spi_data_tx;
    logic        spi_busy;
    logic [7:0]  spi_data_rx;

    // Arbiter side.
    modport slave (
        input  req_0, width_16_0, tx_data_0,
        input  req_1, width_16_1, tx_data_1,
        input  spi_busy, spi_data_rx,
        output grant_0, done_0, grant_1, done_1,
        output rx_data, error,
        output spi_start, spi_width_16, spi_data_tx
    );

    // Requesters and SPI engine side.
    modport master (
        output req_0, width_16_0, tx_data_0,
        output req_1, width_16_1, tx_data_1,
        output spi_busy, spi_data_rx,
        input  grant_0, done_0, grant_1, done_1,
        input  rx_data, error,
        input  spi_start, spi_width_16, spi_data_tx
    );

endinterface
`default_nettype wire

// File: rtl/spi_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module : spi_arbiter_rr_arb2
// Combinational two-way round-robin pick.
// Rev    : 1.0
// ============================================================================
module spi_arbiter_rr_arb2
    import spi_arbiter_pkg::*;
(
    input  wire  req_0_i,
    input  wire  req_1_i,
    input  wire  last_grant_i,
    output logic valid_o,
    output logic pick_o
);

    always_comb begin
        valid_o = req_0_i | req_1_i;
        pick_o  = rr_pick(req_0_i, req_1_i, last_grant_i);
    end

endmodule
`default_nettype wire

// File: rtl/spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module : spi_arbiter
// Shares one SPI engine between two requesters with round-robin arbitration.
// Rev    : 1.0
// ============================================================================
module spi_arbiter
    import spi_arbiter_pkg::*;
#(
    parameter int unsigned START_TIMEOUT = START_TIMEOUT_DEFAULT,
    parameter int unsigned TIMEOUT_W     = TIMEOUT_W_DEFAULT
)(
    input  wire          raw_clk,
    input  wire          reset,
    spi_arbiter_if.slave bus
);

    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = TIMEOUT_W'(START_TIMEOUT);

    arb_state_t           state_q;
    logic                 grant_0_q;
    logic                 grant_1_q;
    logic                 done_0_q;
    logic                 done_1_q;
    logic                 error_q;
    logic                 spi_start_q;
    logic                 spi_width_16_q;
    logic [15:0]          spi_data_tx_q;
    logic [7:0]           rx_data_q;
    logic                 last_grant_q;
    logic                 timeout_q;
    logic [TIMEOUT_W-1:0] count_q;

    logic                 win_valid;
    logic                 win_idx;

    spi_arbiter_rr_arb2 u_rr_arb2 (
        .req_0_i      (bus.req_0),
        .req_1_i      (bus.req_1),
        .last_grant_i (last_grant_q),
        .valid_o      (win_valid),
        .pick_o       (win_idx)
    );

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            grant_0_q      <= 1'b0;
            grant_1_q      <= 1'b0;
            done_0_q       <= 1'b0;
            done_1_q       <= 1'b0;
            error_q        <= 1'b0;
            spi_start_q    <= 1'b0;
            spi_width_16_q <= 1'b0;
            spi_data_tx_q  <= 16'h0000;
            rx_data_q      <= 8'h00;
            last_grant_q   <= 1'b1;
            timeout_q      <= 1'b0;
            count_q        <= '0;
        end else begin
            done_0_q <= 1'b0;
            done_1_q <= 1'b0;
            error_q  <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    // A busy engine here means we were reset mid-transfer; let it drain.
                    if (!bus.spi_busy && win_valid) begin
                        grant_0_q      <= ~win_idx;
                        grant_1_q      <= win_idx;
                        spi_width_16_q <= win_idx ? bus.width_16_1 : bus.width_16_0;
                        spi_data_tx_q  <= win_idx ? bus.tx_data_1  : bus.tx_data_0;
                        spi_start_q    <= 1'b1;
                        last_grant_q   <= win_idx;
                        count_q        <= '0;
                        state_q        <= ST_START;
                    end
                end

                ST_START: begin
                    if (bus.spi_busy) begin
                        spi_start_q <= 1'b0;
                        state_q     <= ST_WAIT;
                    end else if (count_q == TIMEOUT_LIMIT) begin
                        spi_start_q <= 1'b0;
                        timeout_q   <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end

                ST_WAIT: begin
                    if (!bus.spi_busy) begin
                        state_q <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // A timed-out transfer never ran, so the last good byte is kept.
                    if (!timeout_q) begin
                        rx_data_q <= bus.spi_data_rx;
                    end
                    done_0_q  <= grant_0_q;
                    done_1_q  <= grant_1_q;
                    error_q   <= timeout_q;
                    grant_0_q <= 1'b0;
                    grant_1_q <= 1'b0;
                    timeout_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.grant_0      = grant_0_q;
    assign bus.grant_1      = grant_1_q;
    assign bus.done_0       = done_0_q;
    assign bus.done_1       = done_1_q;
    assign bus.error        = error_q;
    assign bus.rx_data      = rx_data_q;
    assign bus.spi_start    = spi_start_q;
    assign bus.spi_width_16 = spi_width_16_q;
    assign bus.spi_data_tx  = spi_data_tx_q;

endmodule
`default_nettype wire
